// File: rtl/mips_wbuf_pkg.sv
// Shared widths, FSM state and entry types for the MIPS posted-write buffer.
package mips_wbuf_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    RD_ISSUE = 2'd3
  } wbuf_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wbuf_entry_t;

  // Two byte addresses fall in the same 32-bit word.
  function automatic logic word_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:2] == b[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/mips_write_buffer_if.sv
// Avalon-style word bus used on both the CPU side and the memory side of the buffer.
interface mips_write_buffer_if;
  import mips_wbuf_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_wbuf_fifo.sv
// Circular store queue for the write buffer.
// Build option: MIPS_WBUF_FORWARD_EN exposes every entry, oldest first, for forwarding.
module mips_wbuf_fifo
  import mips_wbuf_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wbuf_entry_t      push_entry,
  output wbuf_entry_t      head,
  output wbuf_entry_t      head_next,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef MIPS_WBUF_FORWARD_EN
  ,
  output wbuf_entry_t [DEPTH-1:0] ordered,
  output logic [DEPTH-1:0]        valid
`endif
);

  wbuf_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset; the count alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_q + PTR_W'(1)];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

`ifdef MIPS_WBUF_FORWARD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ordered[i] = mem_q[rd_ptr_q + PTR_W'(i)];
      valid[i]   = (CNT_W'(i) < count_q);
    end
  end
`endif

endmodule

// File: rtl/mips_write_buffer.sv
// Posted-write buffer: CPU stores are queued and drained in order; reads wait behind them.
// Build option: MIPS_WBUF_FORWARD_EN returns data from a queued full-word store.
module mips_write_buffer
  import mips_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mips_write_buffer_if.slave  cpu,
  mips_write_buffer_if.master mem,
  output logic                wb_empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wbuf_state_t       state_q;
  wbuf_entry_t       cpu_entry;
  wbuf_entry_t       head;
  wbuf_entry_t       head_next;
  wbuf_entry_t       issue_entry;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              avail;
  logic              more_writes;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              stall_c;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              read_q;
  logic              write_q;
  logic [DATA_W-1:0] rd_data_q;

  assign cpu_entry = '{addr: cpu.address, data: cpu.writedata, be: cpu.byteenable};
  assign push      = cpu.write && !full;
  assign pop       = (state_q == WR_ISSUE) && !mem.waitrequest;

`ifdef MIPS_WBUF_FORWARD_EN
  wbuf_entry_t [DEPTH-1:0] fwd_entries;
  logic [DEPTH-1:0]        fwd_valid;
`endif

  mips_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry (cpu_entry),
    .head       (head),
    .head_next  (head_next),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef MIPS_WBUF_FORWARD_EN
    ,
    .ordered    (fwd_entries),
    .valid      (fwd_valid)
`endif
  );

  // Next store to present on the bus; a store pushed into an empty queue goes out directly.
  always_comb begin
    avail       = (count > CNT_W'(state_q == WR_ISSUE));
    issue_entry = cpu_entry;
    if (avail) issue_entry = (state_q == WR_ISSUE) ? head_next : head;
    more_writes = avail || push;
  end

`ifdef MIPS_WBUF_FORWARD_EN
  // The queue leaves IDLE on the push cycle, so the match also runs while draining.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (cpu.read && (state_q == IDLE || state_q == WR_ISSUE)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fwd_valid[i] && word_match(fwd_entries[i].addr, cpu.address)) begin
          fwd_hit  = &fwd_entries[i].be;
          fwd_data = fwd_entries[i].data;
        end
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    stall_c = 1'b0;
    if (cpu.write)     stall_c = full;
    else if (cpu.read) stall_c = (state_q != RD_WAIT) && !fwd_hit;
  end

  assign cpu.waitrequest = stall_c;
  assign cpu.readdata    = fwd_hit ? fwd_data : rd_data_q;

  // Drain FSM with registered memory-side strobes and payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (more_writes) begin
            state_q <= WR_ISSUE;
            write_q <= 1'b1;
            addr_q  <= issue_entry.addr;
            wdata_q <= issue_entry.data;
            be_q    <= issue_entry.be;
          end else if (cpu.read && !fwd_hit) begin
            state_q <= RD_ISSUE;
            read_q  <= 1'b1;
            addr_q  <= cpu.address;
            be_q    <= cpu.byteenable;
          end
        end
        WR_ISSUE: begin
          if (!mem.waitrequest) begin
            if (more_writes) begin
              addr_q  <= issue_entry.addr;
              wdata_q <= issue_entry.data;
              be_q    <= issue_entry.be;
            end else begin
              state_q <= IDLE;
              write_q <= 1'b0;
            end
          end
        end
        RD_ISSUE: begin
          if (!mem.waitrequest) begin
            state_q   <= RD_WAIT;
            read_q    <= 1'b0;
            rd_data_q <= mem.readdata;
          end
        end
        RD_WAIT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.address    = addr_q;
  assign mem.writedata  = wdata_q;
  assign mem.byteenable = be_q;
  assign mem.read       = read_q;
  assign mem.write      = write_q;
  assign wb_empty       = empty;

endmodule

// File: tb/tb_mips_write_buffer.sv
// Directed bench for mips_write_buffer; covers both MIPS_WBUF_FORWARD_EN builds.
module tb_mips_write_buffer;
  import mips_wbuf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic wb_empty;
  int   n_checks = 0;
  int   n_errors = 0;

  // Memory-side handshakes as {is_read, address}, in completion order.
  logic [32:0] ev_q[$];

  mips_write_buffer_if cpu_if ();
  mips_write_buffer_if mem_if ();

  always #5 clk = ~clk;

  mips_write_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu      (cpu_if),
    .mem      (mem_if),
    .wb_empty (wb_empty)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_if.write && !mem_if.waitrequest) ev_q.push_back({1'b0, mem_if.address});
      if (mem_if.read && !mem_if.waitrequest)  ev_q.push_back({1'b1, mem_if.address});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ev_at(input int i);
    return (i < ev_q.size()) ? ev_q[i] : 33'h1_FFFF_FFFF;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    n = 0;
    cpu_if.write      = 1'b1;
    cpu_if.address    = a;
    cpu_if.writedata  = d;
    cpu_if.byteenable = be;
    #1;
    while (cpu_if.waitrequest && n < 50) begin
      cycle();
      n++;
    end
    check("wr_accept_timeout", 64'(n >= 50), 64'(0));
    cycle();
    cpu_if.write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] be,
                         output logic [31:0] data, output int stalls);
    stalls            = 0;
    cpu_if.read       = 1'b1;
    cpu_if.address    = a;
    cpu_if.byteenable = be;
    #1;
    while (cpu_if.waitrequest && stalls < 50) begin
      cycle();
      stalls++;
    end
    data = cpu_if.readdata;
    cycle();
    cpu_if.read = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!wb_empty && n < 50) begin
      cycle();
      n++;
    end
    check(tag, 64'(wb_empty), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    int          stalls;

    reset                = 1'b1;
    cpu_if.address       = '0;
    cpu_if.read          = 1'b0;
    cpu_if.write         = 1'b0;
    cpu_if.writedata     = '0;
    cpu_if.byteenable    = '0;
    mem_if.waitrequest   = 1'b0;
    mem_if.readdata      = '0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_mem_write",   64'(mem_if.write),      64'(0));
    check("rst_mem_read",    64'(mem_if.read),       64'(0));
    check("rst_mem_address", 64'(mem_if.address),    64'(0));
    check("rst_mem_wdata",   64'(mem_if.writedata),  64'(0));
    check("rst_mem_be",      64'(mem_if.byteenable), 64'(0));
    check("rst_wb_empty",    64'(wb_empty),          64'(1));
    check("rst_cpu_wait",    64'(cpu_if.waitrequest),64'(0));
    check("rst_cpu_rdata",   64'(cpu_if.readdata),   64'(0));
    reset = 1'b0;
    cycle();

    // Single store with no memory wait.
    ev_q.delete();
    cpu_if.write      = 1'b1;
    cpu_if.address    = 32'h100;
    cpu_if.writedata  = 32'hDEADBEEF;
    cpu_if.byteenable = 4'hF;
    #1;
    check("t1_push_wait", 64'(cpu_if.waitrequest), 64'(0));
    cycle();
    cpu_if.write = 1'b0;
    check("t1_mem_write",   64'(mem_if.write),      64'(1));
    check("t1_mem_address", 64'(mem_if.address),    64'(32'h100));
    check("t1_mem_wdata",   64'(mem_if.writedata),  64'(32'hDEADBEEF));
    check("t1_mem_be",      64'(mem_if.byteenable), 64'(4'hF));
    check("t1_busy",        64'(wb_empty),          64'(0));
    cycle();
    check("t1_mem_write_off", 64'(mem_if.write), 64'(0));
    check("t1_empty",         64'(wb_empty),     64'(1));
    check("t1_ev_count",      64'(ev_q.size()),  64'(1));
    check("t1_ev0",           64'(ev_at(0)),     64'({1'b0, 32'h100}));

    // Fill to full while memory stalls; fifth store waits for a pop.
    ev_q.delete();
    mem_if.waitrequest = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cpu_if.write      = 1'b1;
      cpu_if.address    = 32'(4 * k);
      cpu_if.writedata  = 32'hA0 + 32'(k);
      cpu_if.byteenable = 4'hF;
      #1;
      check("t2_accept", 64'(cpu_if.waitrequest), 64'(0));
      cycle();
    end
    cpu_if.address   = 32'h10;
    cpu_if.writedata = 32'hA4;
    #1;
    check("t2_full_stall", 64'(cpu_if.waitrequest), 64'(1));
    cycle();
    check("t2_full_stall", 64'(cpu_if.waitrequest), 64'(1));
    cycle();
    check("t2_full_stall", 64'(cpu_if.waitrequest), 64'(1));
    mem_if.waitrequest = 1'b0;
    #1;
    check("t2_pop_cycle_stall", 64'(cpu_if.waitrequest), 64'(1));
    cycle();
    check("t2_slot_free", 64'(cpu_if.waitrequest), 64'(0));
    cycle();
    cpu_if.write = 1'b0;
    wait_empty("t2_drain");
    check("t2_ev_count", 64'(ev_q.size()), 64'(5));
    for (int k = 0; k < 5; k++) begin
      check("t2_order", 64'(ev_at(k)), 64'({1'b0, 32'(4 * k)}));
    end

    // Read strictly behind two queued stores.
    ev_q.delete();
    mem_if.readdata = 32'h12345678;
    do_write(32'h20, 32'h11111111, 4'hF);
    do_write(32'h24, 32'h22222222, 4'hF);
    do_read(32'h200, 4'hF, rdata, stalls);
    check("t3_rdata",    64'(rdata),         64'(32'h12345678));
    check("t3_stalls",   64'(stalls),        64'(3));
    check("t3_ev_count", 64'(ev_q.size()),   64'(3));
    check("t3_ev0",      64'(ev_at(0)),      64'({1'b0, 32'h20}));
    check("t3_ev1",      64'(ev_at(1)),      64'({1'b0, 32'h24}));
    check("t3_ev2",      64'(ev_at(2)),      64'({1'b1, 32'h200}));
    check("t3_read_off", 64'(mem_if.read),   64'(0));

    // Read from an empty buffer: minimum latency.
    ev_q.delete();
    mem_if.readdata = 32'h0BADF00D;
    do_read(32'h300, 4'hF, rdata, stalls);
    check("t3b_rdata",  64'(rdata),       64'(32'h0BADF00D));
    check("t3b_stalls", 64'(stalls),      64'(2));
    check("t3b_ev0",    64'(ev_at(0)),    64'({1'b1, 32'h300}));
    check("t3b_empty",  64'(wb_empty),    64'(1));

`ifdef MIPS_WBUF_FORWARD_EN
    // Full-word store is forwarded in the same cycle without touching memory.
    ev_q.delete();
    mem_if.waitrequest = 1'b1;
    do_write(32'h40, 32'hCAFEF00D, 4'hF);
    cpu_if.read       = 1'b1;
    cpu_if.address    = 32'h40;
    cpu_if.byteenable = 4'hF;
    #1;
    check("t4_fwd_wait",  64'(cpu_if.waitrequest), 64'(0));
    check("t4_fwd_rdata", 64'(cpu_if.readdata),    64'(32'hCAFEF00D));
    check("t4_fwd_nomem", 64'(mem_if.read),        64'(0));
    cycle();
    cpu_if.read = 1'b0;
    mem_if.waitrequest = 1'b0;
    wait_empty("t4_drain");
    check("t4_ev_count", 64'(ev_q.size()), 64'(1));
    check("t4_ev0",      64'(ev_at(0)),    64'({1'b0, 32'h40}));

    // Partial store to the same word forces the read to wait for empty.
    ev_q.delete();
    mem_if.waitrequest = 1'b1;
    do_write(32'h41, 32'h0000AB00, 4'b0010);
    cpu_if.read       = 1'b1;
    cpu_if.address    = 32'h40;
    cpu_if.byteenable = 4'hF;
    #1;
    check("t4_partial_wait", 64'(cpu_if.waitrequest), 64'(1));
    cycle();
    check("t4_partial_wait", 64'(cpu_if.waitrequest), 64'(1));
    mem_if.waitrequest = 1'b0;
    mem_if.readdata    = 32'h600DCAFE;
    do_read(32'h40, 4'hF, rdata, stalls);
    check("t4_partial_rdata",  64'(rdata),    64'(32'h600DCAFE));
    check("t4_partial_stalls", 64'(stalls),   64'(3));
    check("t4_partial_ev0",    64'(ev_at(0)), 64'({1'b0, 32'h41}));
    check("t4_partial_ev1",    64'(ev_at(1)), 64'({1'b1, 32'h40}));
`else
    // Without forwarding a read to a queued address waits for the drain.
    ev_q.delete();
    mem_if.waitrequest = 1'b1;
    do_write(32'h40, 32'hCAFEF00D, 4'hF);
    cpu_if.read       = 1'b1;
    cpu_if.address    = 32'h40;
    cpu_if.byteenable = 4'hF;
    #1;
    check("t4_nofwd_wait", 64'(cpu_if.waitrequest), 64'(1));
    cycle();
    check("t4_nofwd_wait", 64'(cpu_if.waitrequest), 64'(1));
    mem_if.waitrequest = 1'b0;
    mem_if.readdata    = 32'h55AA55AA;
    do_read(32'h40, 4'hF, rdata, stalls);
    check("t4_nofwd_rdata",  64'(rdata),    64'(32'h55AA55AA));
    check("t4_nofwd_stalls", 64'(stalls),   64'(3));
    check("t4_nofwd_ev0",    64'(ev_at(0)), 64'({1'b0, 32'h40}));
    check("t4_nofwd_ev1",    64'(ev_at(1)), 64'({1'b1, 32'h40}));
`endif

    // Asynchronous reset with three stores queued and a write on the bus.
    ev_q.delete();
    mem_if.waitrequest = 1'b1;
    do_write(32'h80, 32'h80808080, 4'hF);
    do_write(32'h84, 32'h84848484, 4'hF);
    do_write(32'h88, 32'h88888888, 4'hF);
    check("t5_write_before", 64'(mem_if.write), 64'(1));
    check("t5_busy_before",  64'(wb_empty),     64'(0));
    #3;
    reset = 1'b1;
    #1;
    check("t5_write_async", 64'(mem_if.write),   64'(0));
    check("t5_empty_async", 64'(wb_empty),       64'(1));
    check("t5_addr_async",  64'(mem_if.address), 64'(0));
    cycle();
    reset = 1'b0;
    mem_if.waitrequest = 1'b0;
    repeat (10) cycle();
    check("t5_no_writes",  64'(ev_q.size()),  64'(0));
    check("t5_write_idle", 64'(mem_if.write), 64'(0));
    check("t5_empty",      64'(wb_empty),     64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_write_buffer.md
# mips_write_buffer

Posted-write buffer between the MIPS CPU's Avalon-style bus master port and the memory slave. CPU stores are accepted in one cycle and queued, then drained to memory in order while the CPU continues. Reads (instruction fetch and loads) are strictly ordered behind all queued writes. Memory therefore sees the exact program-order access sequence, with store stalls hidden from the CPU.

## Interface
- DEPTH, 4, number of buffered write entries (power of two, ≥2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_address  in  32  CPU byte address
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request (never asserted together with cpu_read)
- cpu_writedata  in  32  CPU store data
- cpu_byteenable  in  4  CPU byte lanes
- cpu_waitrequest  out  1  stall back to CPU
- cpu_readdata  out  32  read data; valid in the cycle cpu_waitrequest is low with cpu_read high
- mem_address  out  32  memory byte address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_writedata  out  32  memory store data
- mem_byteenable  out  4  memory byte lanes
- mem_waitrequest  in  1  memory stall
- mem_readdata  in  32  memory read data; valid in the cycle mem_waitrequest is low with mem_read high
- wb_empty  out  1  high when no writes are queued and none in flight; CPU keeps active high until wb_empty

## Operation
- FIFO of {address, writedata, byteenable} entries; registered count 0..DEPTH; pointers wrap modulo DEPTH.
- CPU write: accepted (push) in any cycle where count < DEPTH; cpu_waitrequest = cpu_write & (count == DEPTH). Full check uses the registered count, so a pop in the same cycle does not free a slot until the next cycle.
- Drain FSM states: IDLE, WR_ISSUE, RD_WAIT, RD_ISSUE.
- IDLE: if count > 0 → WR_ISSUE (head driven on mem_*). Otherwise, if cpu_read is high and the forwarding path does not apply → RD_ISSUE.
- WR_ISSUE: mem_write held with stable mem_* until mem_waitrequest is low, then pop. Next state is WR_ISSUE if entries remain, else IDLE.
- cpu_read while count > 0 and no forward hit: cpu_waitrequest stays high. The FSM keeps draining and enters RD_ISSUE only after the last write completes.
- RD_ISSUE: mem_read=1 with mem_address=cpu_address, mem_byteenable=cpu_byteenable. When mem_waitrequest is low, the value of mem_readdata is registered into cpu_readdata. The FSM then moves to RD_WAIT.
- RD_WAIT: cpu_waitrequest=0 for exactly one cycle, then → IDLE.
- CPU write arriving during RD_*: cannot occur (the CPU is stalled). If it does occur, it is pushed normally.
- Reset at any time: count=0, all queued writes discarded, FSM=IDLE, all outputs take reset values at once.

## Timing
- Reset values: cpu_waitrequest=0, cpu_readdata=0, mem_address=0, mem_read=0, mem_write=0, mem_writedata=0, mem_byteenable=0, wb_empty=1.
- Write accept latency: 0 cycles when not full. The first mem_write is asserted the cycle after the push.
- Write throughput: one entry per cycle when mem_waitrequest is low (back-to-back WR_ISSUE).
- Read latency with an empty buffer: request cycle → RD_ISSUE next cycle → RD_WAIT after mem handshake. Minimum is 2 cycles of cpu_waitrequest high; data is returned in the third cycle.
- All mem_* outputs are registered. cpu_waitrequest is combinational from state, count and the cpu request.

## Configuration
- MIPS_WBUF_FORWARD_EN defined: a cpu_read in IDLE is checked against all valid entries.
  - Returning data: the newest entry with an equal word address and byteenable 4'b1111 is returned combinationally in the same cycle, with cpu_waitrequest=0 and no memory access.
  - Waiting: a word-address match on an entry with a partial byteenable waits for empty.
- MIPS_WBUF_FORWARD_EN undefined: every read waits for an empty buffer. Forwarding comparators are not built.

## Structure
- Package mips_wbuf_pkg:
  - wbuf_state_t enum (IDLE, WR_ISSUE, RD_WAIT, RD_ISSUE).
  - wbuf_entry_t packed struct {addr[31:0], data[31:0], be[3:0]}.
  - Localparams ADDR_W=32, DATA_W=32.
- Sub-module mips_wbuf_fifo: parameterised storage, pointers, count, full/empty flags, and, when forwarding is enabled, per-entry read-out for the comparators.
- The top module holds the FSM and the bus muxing.

## Test plan
- Single store, zero memory wait: sw 0xDEADBEEF to 0x100, be 4'b1111. Expected: cpu_waitrequest=0 on the push cycle, mem_write for one cycle the next cycle, wb_empty=1 after that.
- Fill to full with mem_waitrequest held high: 5 stores with DEPTH=4. Expected: the fifth store stalls until the first pop; memory receives the writes in order 0x0, 0x4, 0x8, 0xC, 0x10.
- Read behind writes: 2 stores then lw 0x200 (memory returns 0x12345678). Expected: mem_read only after both mem_writes complete; cpu_readdata=0x12345678.
- Forwarding (macro on): sw 0xCAFEF00D to 0x40, then lw 0x40 while memory is stalled. Expected: same-cycle cpu_readdata=0xCAFEF00D and no mem_read. With a partial store (sb to 0x40) first, the read waits for empty.
- Asynchronous reset while 3 entries are queued and mem_write is high. Expected: mem_write drops immediately, wb_empty=1, no further memory writes.
